wb_bus_arbiter: RTL and testbench

Two-master to one-slave Wishbone B4 (classic) arbiter. It lets the core's instruction-fetch port and data-access port share a single memory or peripheral bus. The arbiter holds the grant for a whole bus cycle (while the granted master keeps `cyc` high) and alternates round-robin on contention. A per-access timeout counter terminates hung slaves with `err`. It sits between the core's two WB4 master ports and the system memory slave.

---
 rtl/global_pkg.sv | 21 ++
 rtl/wb_bus_arbiter_if.sv | 21 ++
 rtl/wb_timeout_counter.sv | 30 +++
 rtl/wb_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/global_pkg.sv
// Shared types for the two-master Wishbone arbiter.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : identity of the master that last held the bus
package global_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INST = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Wishbone B4 classic bus bundle.
//   master modport : drives cyc/stb/we/adr/dat_w/sel, receives ack/err/dat_r
//   slave modport  : the reverse direction
interface wb_bus_arbiter_if;
  import global_pkg::*;

  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_w;
  logic [SEL_W-1:0] sel;
  logic             ack;
  logic             err;
  logic [DAT_W-1:0] dat_r;

  modport master (output cyc, stb, we, adr, dat_w, sel,
                  input  ack, err, dat_r);
  modport slave  (input  cyc, stb, we, adr, dat_w, sel,
                  output ack, err, dat_r);
endinterface

// File: rtl/wb_timeout_counter.sv
// Counts strobed cycles without a slave response.
//   clk, rst  : clock, synchronous active-high reset
//   count_en  : advance the count this cycle
//   clear     : zero the count at the next edge (beats count_en)
//   expired   : count has reached TIMEOUT (never set when TIMEOUT is 0)
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master to one-slave Wishbone B4 classic arbiter with round-robin
// tie-break, cycle-level grant locking and a per-access timeout.
//   clk, rst      : clock, synchronous active-high reset
//   inst_bus      : instruction-fetch master (slave modport)
//   data_bus      : data-access master (slave modport)
//   mem_bus       : shared slave side (master modport)
//   timeout_pulse : one-cycle pulse the cycle after a timeout fires
module wb_bus_arbiter
  import global_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  wb_bus_arbiter_if.slave     inst_bus,
  wb_bus_arbiter_if.slave     data_bus,
  wb_bus_arbiter_if.master    mem_bus,
  output logic                timeout_pulse
);

  arb_state_t       state;
  arb_owner_t       last_grant;

  logic             own_cyc;
  logic             own_stb;
  logic             own_we;
  logic [ADR_W-1:0] own_adr;
  logic [DAT_W-1:0] own_dat_w;
  logic [SEL_W-1:0] own_sel;
  logic             sel_inst;
  logic             sel_data;
  logic             expired;
  logic             fire;

  // Grant FSM; last_grant follows every entry into a granted state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB_IDLE;
      last_grant    <= INST;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= fire;
      case (state)
        ARB_IDLE: begin
          if (inst_bus.cyc && data_bus.cyc) begin
            if (last_grant == INST) begin
              state      <= ARB_DATA;
              last_grant <= DATA;
            end else begin
              state      <= ARB_INST;
              last_grant <= INST;
            end
          end else if (inst_bus.cyc) begin
            state      <= ARB_INST;
            last_grant <= INST;
          end else if (data_bus.cyc) begin
            state      <= ARB_DATA;
            last_grant <= DATA;
          end
        end
        ARB_INST: begin
          if (!inst_bus.cyc) begin
            if (data_bus.cyc) begin
              state      <= ARB_DATA;
              last_grant <= DATA;
            end else begin
              state <= ARB_IDLE;
            end
          end
        end
        ARB_DATA: begin
          if (!data_bus.cyc) begin
            if (inst_bus.cyc) begin
              state      <= ARB_INST;
              last_grant <= INST;
            end else begin
              state <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Request mux from the current owner; all zero when idle.
  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_adr   = '0;
    own_dat_w = '0;
    own_sel   = '0;
    case (state)
      ARB_INST: begin
        own_cyc   = inst_bus.cyc;
        own_stb   = inst_bus.stb;
        own_we    = inst_bus.we;
        own_adr   = inst_bus.adr;
        own_dat_w = inst_bus.dat_w;
        own_sel   = inst_bus.sel;
      end
      ARB_DATA: begin
        own_cyc   = data_bus.cyc;
        own_stb   = data_bus.stb;
        own_we    = data_bus.we;
        own_adr   = data_bus.adr;
        own_dat_w = data_bus.dat_w;
        own_sel   = data_bus.sel;
      end
      default: ;
    endcase
  end

  assign sel_inst = (state == ARB_INST);
  assign sel_data = (state == ARB_DATA);

  // Reset gates the slave side immediately so an aborted beat never reaches it.
  assign mem_bus.cyc   = ~rst & own_cyc;
  assign mem_bus.stb   = ~rst & own_stb & ~expired;
  assign mem_bus.we    = ~rst & own_we;
  assign mem_bus.adr   = rst ? '0 : own_adr;
  assign mem_bus.dat_w = rst ? '0 : own_dat_w;
  assign mem_bus.sel   = rst ? '0 : own_sel;

  // A slave ack arriving at the limit wins over the timeout.
  assign fire = expired & ~mem_bus.ack;

  assign inst_bus.ack   = sel_inst & mem_bus.ack;
  assign inst_bus.err   = sel_inst & (mem_bus.err | fire);
  assign inst_bus.dat_r = sel_inst ? mem_bus.dat_r : '0;
  assign data_bus.ack   = sel_data & mem_bus.ack;
  assign data_bus.err   = sel_data & (mem_bus.err | fire);
  assign data_bus.dat_r = sel_data ? mem_bus.dat_r : '0;

  // Owner dropping cyc is exactly a state change, so it clears the count too.
  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .count_en (own_stb & ~mem_bus.ack & ~mem_bus.err),
    .clear    (~own_cyc | ~own_stb | mem_bus.ack | mem_bus.err | expired),
    .expired  (expired)
  );

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared every cycle against an ownership model.
module tb_wb_bus_arbiter;
  import global_pkg::*;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic timeout_pulse;

  always #5 clk = ~clk;

  wb_bus_arbiter_if inst_bus ();
  wb_bus_arbiter_if data_bus ();
  wb_bus_arbiter_if mem_bus ();

  wb_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_bus      (inst_bus),
    .data_bus      (data_bus),
    .mem_bus       (mem_bus),
    .timeout_pulse (timeout_pulse)
  );

  // Reference model: who owns the bus (0 none, 1 inst, 2 data), who last owned
  // it, how many unanswered strobed cycles have elapsed, and the pending pulse.
  int own;
  int last;
  int waited;
  bit pulse_exp;
  int n_checks;
  int n_pass;
  bit quiet;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic clear_inputs();
    inst_bus.cyc = 0; inst_bus.stb = 0; inst_bus.we = 0;
    inst_bus.adr = 0; inst_bus.dat_w = 0; inst_bus.sel = 0;
    data_bus.cyc = 0; data_bus.stb = 0; data_bus.we = 0;
    data_bus.adr = 0; data_bus.dat_w = 0; data_bus.sel = 0;
    mem_bus.ack = 0; mem_bus.err = 0; mem_bus.dat_r = 0;
  endtask

  // Compare all outputs against the model mid-cycle, then advance the model.
  task automatic step();
    logic        oc, os, ow, exp_to, fire, other_cyc;
    logic [31:0] oa, od;
    logic [3:0]  osel;
    int          nxt;
    @(negedge clk);
    exp_to = (TO != 0) && (waited == int'(TO));
    oc = 0; os = 0; ow = 0; oa = 0; od = 0; osel = 0; other_cyc = 0;
    if (own == 1) begin
      oc = inst_bus.cyc; os = inst_bus.stb; ow = inst_bus.we;
      oa = inst_bus.adr; od = inst_bus.dat_w; osel = inst_bus.sel;
      other_cyc = data_bus.cyc;
    end else if (own == 2) begin
      oc = data_bus.cyc; os = data_bus.stb; ow = data_bus.we;
      oa = data_bus.adr; od = data_bus.dat_w; osel = data_bus.sel;
      other_cyc = inst_bus.cyc;
    end
    fire = exp_to && !mem_bus.ack;
    check("s_cyc",   32'(mem_bus.cyc),   32'(!rst && oc));
    check("s_stb",   32'(mem_bus.stb),   32'(!rst && oc && os && !exp_to));
    check("s_we",    32'(mem_bus.we),    32'(!rst && ow));
    check("s_adr",   mem_bus.adr,        rst ? 32'h0 : oa);
    check("s_dat_w", mem_bus.dat_w,      rst ? 32'h0 : od);
    check("s_sel",   32'(mem_bus.sel),   rst ? 32'h0 : 32'(osel));
    check("i_ack",   32'(inst_bus.ack),  32'(own == 1 && mem_bus.ack));
    check("i_err",   32'(inst_bus.err),  32'(own == 1 && (mem_bus.err || fire)));
    check("i_dat_r", inst_bus.dat_r,     own == 1 ? mem_bus.dat_r : 32'h0);
    check("d_ack",   32'(data_bus.ack),  32'(own == 2 && mem_bus.ack));
    check("d_err",   32'(data_bus.err),  32'(own == 2 && (mem_bus.err || fire)));
    check("d_dat_r", data_bus.dat_r,     own == 2 ? mem_bus.dat_r : 32'h0);
    check("pulse",   32'(timeout_pulse), 32'(pulse_exp));
    if (rst) begin
      own = 0; last = 1; waited = 0; pulse_exp = 0;
    end else begin
      nxt = own;
      if (own == 0) begin
        if (inst_bus.cyc && data_bus.cyc) nxt = (last == 1) ? 2 : 1;
        else if (inst_bus.cyc) nxt = 1;
        else if (data_bus.cyc) nxt = 2;
      end else if (!oc) begin
        nxt = other_cyc ? 3 - own : 0;
      end
      if (own == 0 || nxt != own || !os || mem_bus.ack || mem_bus.err || exp_to) waited = 0;
      else waited++;
      if (nxt != 0) last = nxt;
      pulse_exp = fire;
      own = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic drive_random();
    if (inst_bus.cyc) inst_bus.cyc = ($urandom_range(0, 5) != 0);
    else inst_bus.cyc = ($urandom_range(0, 3) == 0);
    if (data_bus.cyc) data_bus.cyc = ($urandom_range(0, 5) != 0);
    else data_bus.cyc = ($urandom_range(0, 3) == 0);
    inst_bus.stb = inst_bus.cyc && ($urandom_range(0, 3) != 0);
    data_bus.stb = data_bus.cyc && ($urandom_range(0, 3) != 0);
    inst_bus.we = 1'($urandom); data_bus.we = 1'($urandom);
    inst_bus.adr = $urandom; data_bus.adr = $urandom;
    inst_bus.dat_w = $urandom; data_bus.dat_w = $urandom;
    inst_bus.sel = 4'($urandom); data_bus.sel = 4'($urandom);
    if ($urandom_range(0, 39) == 0) quiet = ~quiet;
    mem_bus.ack = !quiet && ($urandom_range(0, 2) == 0);
    mem_bus.err = !quiet && ($urandom_range(0, 11) == 0);
    mem_bus.dat_r = $urandom;
    rst = ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    int first_err;
    n_checks = 0; n_pass = 0; quiet = 0;
    own = 0; last = 1; waited = 0; pulse_exp = 0;
    clear_inputs();
    rst = 1;
    @(posedge clk);
    #1;
    do_reset();

    // Single master with an ack one cycle after the grant.
    data_bus.cyc = 1; data_bus.stb = 1; data_bus.adr = 32'h100;
    #1; check("single_idle_cyc", 32'(mem_bus.cyc), 32'h0);
    step();
    mem_bus.ack = 1; mem_bus.dat_r = 32'hCAFE_0001;
    #1;
    check("single_s_cyc", 32'(mem_bus.cyc), 32'h1);
    check("single_s_adr", mem_bus.adr, 32'h100);
    check("single_d_ack", 32'(data_bus.ack), 32'h1);
    check("single_i_ack", 32'(inst_bus.ack), 32'h0);
    step();
    do_reset();

    // Tie after reset goes to DATA, then INST, then DATA again.
    inst_bus.cyc = 1; inst_bus.stb = 1; inst_bus.adr = 32'h10;
    data_bus.cyc = 1; data_bus.stb = 1; data_bus.adr = 32'hD0;
    step();
    #1; check("tie1_data", mem_bus.adr, 32'hD0);
    data_bus.cyc = 0; data_bus.stb = 0;
    step();
    #1; check("tie_handover_inst", mem_bus.adr, 32'h10);
    inst_bus.cyc = 0; inst_bus.stb = 0;
    step();
    inst_bus.cyc = 1; inst_bus.stb = 1; data_bus.cyc = 1; data_bus.stb = 1;
    step();
    #1; check("tie2_data", mem_bus.adr, 32'hD0);
    do_reset();

    // Locked four-beat INST burst with DATA waiting throughout.
    inst_bus.cyc = 1; inst_bus.stb = 1; inst_bus.adr = 32'h40;
    step();
    data_bus.cyc = 1; data_bus.stb = 1; data_bus.adr = 32'h80;
    mem_bus.ack = 1;
    for (int b = 0; b < 4; b++) begin
      inst_bus.adr = 32'h40 + 32'(4 * b);
      #1;
      check("burst_adr", mem_bus.adr, 32'h40 + 32'(4 * b));
      check("burst_i_ack", 32'(inst_bus.ack), 32'h1);
      step();
    end
    mem_bus.ack = 0; inst_bus.cyc = 0; inst_bus.stb = 0;
    step();
    #1; check("burst_switch", mem_bus.adr, 32'h80);
    do_reset();

    // Silent slave: err in the 9th strobed cycle, pulse on the next.
    data_bus.cyc = 1; data_bus.stb = 1; data_bus.adr = 32'h200;
    step();
    first_err = 0;
    for (int k = 1; k <= 12 && first_err == 0; k++) begin
      #1;
      if (data_bus.err) begin
        first_err = k;
        check("to_s_stb", 32'(mem_bus.stb), 32'h0);
      end
      step();
    end
    check("to_cycle", 32'(first_err), 32'd9);
    check("to_pulse", 32'(timeout_pulse), 32'h1);
    do_reset();

    // Ack exactly at the limit wins over the timeout.
    data_bus.cyc = 1; data_bus.stb = 1;
    step();
    for (int k = 1; k <= 8; k++) step();
    mem_bus.ack = 1;
    #1;
    check("lim_ack", 32'(data_bus.ack), 32'h1);
    check("lim_err", 32'(data_bus.err), 32'h0);
    step();
    check("lim_pulse", 32'(timeout_pulse), 32'h0);
    mem_bus.ack = 0;
    do_reset();

    // Reset while DATA strobes, then a tie must go to DATA.
    data_bus.cyc = 1; data_bus.stb = 1; data_bus.adr = 32'h300;
    step();
    step();
    rst = 1;
    #1; check("rst_mid_s_cyc", 32'(mem_bus.cyc), 32'h0);
    step();
    rst = 0;
    clear_inputs();
    step();
    #1; check("rst_idle_cyc", 32'(mem_bus.cyc), 32'h0);
    inst_bus.cyc = 1; inst_bus.adr = 32'h11;
    data_bus.cyc = 1; data_bus.adr = 32'h22;
    step();
    #1; check("rst_tie_data", mem_bus.adr, 32'h22);
    do_reset();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
